// File: rtl/stack_ctrl.sv
// Hardware stack controller for a 6502-style page-1 stack: multi-byte push/pull
// bus sequencing with ready-stall, TXS load and modulo-256 stack pointer.
module stack_ctrl (
  input  logic        phi2,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [23:0] push_data,
  input  logic [7:0]  txs_data,
  input  logic        rdy,
  input  logic [7:0]  mem_rdata,
  output logic        op_ready,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  output logic [23:0] pull_data,
  output logic        pull_valid,
  output logic [7:0]  sp
);

  typedef enum logic [1:0] {IDLE, PUSH, PULL} state_t;

  localparam logic [2:0] OP_TXS = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;
  localparam logic [7:0] SP_RST = 8'hFD;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  sp_q, sp_d;
  logic [23:0] data_q, data_d;
  logic [23:0] pull_data_q, pull_data_d;
  logic        pull_valid_q, pull_valid_d;
  logic [7:0]  sp_inc;
  logic [1:0]  idx_inc;
  logic [1:0]  wr_idx;

  function automatic logic [7:0] byte_sel(input logic [23:0] word, input logic [1:0] k);
    case (k)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = 8'h00;
    endcase
  endfunction

  function automatic logic [23:0] byte_put(input logic [23:0] word, input logic [1:0] k,
                                           input logic [7:0] b);
    byte_put = word;
    case (k)
      2'd0:    byte_put[7:0]   = b;
      2'd1:    byte_put[15:8]  = b;
      2'd2:    byte_put[23:16] = b;
      default: byte_put = word;
    endcase
  endfunction

  assign sp_inc  = sp_q + 8'd1;
  assign idx_inc = idx_q + 2'd1;
  assign wr_idx  = cnt_q - 2'd1;

  // Opcodes 000..101: op_code[2:1] encodes byte count minus one, op_code[0] selects pull.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sp_d         = sp_q;
    data_d       = data_q;
    pull_data_d  = pull_data_q;
    pull_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (op_code == OP_TXS) begin
            sp_d = txs_data;
          end else if (op_code != OP_RSV) begin
            cnt_d   = op_code[2:1] + 2'd1;
            idx_d   = 2'd0;
            data_d  = push_data;
            state_d = op_code[0] ? PULL : PUSH;
          end
        end
      end
      PUSH: begin
        if (rdy) begin
          sp_d  = sp_q - 8'd1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = IDLE;
        end
      end
      PULL: begin
        if (rdy) begin
          pull_data_d = byte_put(pull_data_q, idx_q, mem_rdata);
          sp_d        = sp_inc;
          idx_d       = idx_inc;
          if (idx_inc == cnt_q) begin
            state_d      = IDLE;
            pull_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      idx_q        <= 2'd0;
      sp_q         <= SP_RST;
      pull_data_q  <= 24'h0;
      pull_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sp_q         <= sp_d;
      pull_data_q  <= pull_data_d;
      pull_valid_q <= pull_valid_d;
    end
  end

  // Operand bytes are only meaningful while an accepted operation is in flight.
  always_ff @(posedge phi2) begin
    data_q <= data_d;
  end

  assign op_ready   = (state_q == IDLE);
  assign mem_we     = (state_q == PUSH);
  assign mem_re     = (state_q == PULL);
  assign mem_addr   = {8'h01, (state_q == PULL) ? sp_inc : sp_q};
  assign mem_wdata  = byte_sel(data_q, wr_idx);
  assign pull_data  = pull_data_q;
  assign pull_valid = pull_valid_q;
  assign sp         = sp_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl: reset, JSR/RTS, wrap, TXS,
// reserved opcode, ready stall and reset abort.
module tb_stack_ctrl;

  logic        phi2;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [23:0] push_data;
  logic [7:0]  txs_data;
  logic        rdy;
  logic [7:0]  mem_rdata;
  logic        op_ready;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [23:0] pull_data;
  logic        pull_valid;
  logic [7:0]  sp;

  int n_cmp = 0;
  int n_err = 0;

  stack_ctrl dut (
    .phi2(phi2), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .push_data(push_data), .txs_data(txs_data), .rdy(rdy), .mem_rdata(mem_rdata),
    .op_ready(op_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .pull_data(pull_data), .pull_valid(pull_valid), .sp(sp)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b1; op_code = 3'b100; push_data = 24'hABCDEF; rdy = 1'b1;
    tick(); tick();
    rst = 1'b0; op_valid = 1'b0;
    n_cmp++; if (sp !== 8'hFD) begin n_err++; $display("FAIL rst_sp: got %h want fd", sp); end
    n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", op_ready); end
    n_cmp++; if ({mem_we, mem_re} !== 2'b00) begin n_err++; $display("FAIL rst_strobes: got %b want 00", {mem_we, mem_re}); end
    n_cmp++; if (pull_valid !== 1'b0) begin n_err++; $display("FAIL rst_pvalid: got %b want 0", pull_valid); end
    n_cmp++; if (pull_data !== 24'h0) begin n_err++; $display("FAIL rst_pdata: got %h want 000000", pull_data); end
  endtask

  task automatic test_jsr();
    op_valid = 1'b1; op_code = 3'b010; push_data = 24'h001234;
    tick();
    op_valid = 1'b0; push_data = 24'hFFFFFF;
    n_cmp++; if ({mem_we, mem_re, op_ready} !== 3'b100) begin n_err++; $display("FAIL jsr_strobes1: got %b want 100", {mem_we, mem_re, op_ready}); end
    n_cmp++; if (mem_addr !== 16'h01FD) begin n_err++; $display("FAIL jsr_addr1: got %h want 01fd", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h12) begin n_err++; $display("FAIL jsr_wdata1: got %h want 12", mem_wdata); end
    tick();
    n_cmp++; if (mem_addr !== 16'h01FC) begin n_err++; $display("FAIL jsr_addr2: got %h want 01fc", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h34) begin n_err++; $display("FAIL jsr_wdata2: got %h want 34", mem_wdata); end
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL jsr_we2: got %b want 1", mem_we); end
    tick();
    n_cmp++; if (sp !== 8'hFB) begin n_err++; $display("FAIL jsr_sp: got %h want fb", sp); end
    n_cmp++; if ({op_ready, mem_we, pull_valid} !== 3'b100) begin n_err++; $display("FAIL jsr_done: got %b want 100", {op_ready, mem_we, pull_valid}); end
  endtask

  task automatic test_rts();
    op_valid = 1'b1; op_code = 3'b011;
    tick();
    op_valid = 1'b0; op_code = 3'b000;
    n_cmp++; if ({mem_re, mem_we} !== 2'b10) begin n_err++; $display("FAIL rts_strobes1: got %b want 10", {mem_re, mem_we}); end
    n_cmp++; if (mem_addr !== 16'h01FC) begin n_err++; $display("FAIL rts_addr1: got %h want 01fc", mem_addr); end
    mem_rdata = 8'h34;
    tick();
    n_cmp++; if (mem_addr !== 16'h01FD) begin n_err++; $display("FAIL rts_addr2: got %h want 01fd", mem_addr); end
    n_cmp++; if (pull_valid !== 1'b0) begin n_err++; $display("FAIL rts_pvalid_mid: got %b want 0", pull_valid); end
    mem_rdata = 8'h12;
    tick();
    mem_rdata = 8'h99;
    n_cmp++; if (pull_valid !== 1'b1) begin n_err++; $display("FAIL rts_pvalid: got %b want 1", pull_valid); end
    n_cmp++; if (pull_data !== 24'h001234) begin n_err++; $display("FAIL rts_pdata: got %h want 001234", pull_data); end
    n_cmp++; if (sp !== 8'hFD) begin n_err++; $display("FAIL rts_sp: got %h want fd", sp); end
    n_cmp++; if ({op_ready, mem_re} !== 2'b10) begin n_err++; $display("FAIL rts_idle: got %b want 10", {op_ready, mem_re}); end
    tick();
    n_cmp++; if (pull_valid !== 1'b0) begin n_err++; $display("FAIL rts_pvalid_pulse: got %b want 0", pull_valid); end
    n_cmp++; if (pull_data !== 24'h001234) begin n_err++; $display("FAIL rts_pdata_hold: got %h want 001234", pull_data); end
  endtask

  task automatic test_wrap();
    op_valid = 1'b1; op_code = 3'b110; txs_data = 8'h00;
    tick();
    n_cmp++; if (sp !== 8'h00) begin n_err++; $display("FAIL txs_sp: got %h want 00", sp); end
    n_cmp++; if ({op_ready, mem_we, mem_re} !== 3'b100) begin n_err++; $display("FAIL txs_nobus: got %b want 100", {op_ready, mem_we, mem_re}); end
    op_code = 3'b000; push_data = 24'h5566AA;
    tick();
    op_valid = 1'b0;
    n_cmp++; if (mem_addr !== 16'h0100) begin n_err++; $display("FAIL wrap_push_addr: got %h want 0100", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'hAA) begin n_err++; $display("FAIL wrap_push_wdata: got %h want aa", mem_wdata); end
    tick();
    n_cmp++; if (sp !== 8'hFF) begin n_err++; $display("FAIL wrap_push_sp: got %h want ff", sp); end
    n_cmp++; if ({op_ready, pull_valid} !== 2'b10) begin n_err++; $display("FAIL wrap_push_done: got %b want 10", {op_ready, pull_valid}); end
    op_valid = 1'b1; op_code = 3'b001;
    tick();
    op_valid = 1'b0;
    n_cmp++; if (mem_addr !== 16'h0100) begin n_err++; $display("FAIL wrap_pull_addr: got %h want 0100", mem_addr); end
    mem_rdata = 8'hAA;
    tick();
    n_cmp++; if (pull_data !== 24'h0012AA) begin n_err++; $display("FAIL wrap_pull_pdata: got %h want 0012aa", pull_data); end
    n_cmp++; if (sp !== 8'h00) begin n_err++; $display("FAIL wrap_pull_sp: got %h want 00", sp); end
    n_cmp++; if (pull_valid !== 1'b1) begin n_err++; $display("FAIL wrap_pull_pvalid: got %b want 1", pull_valid); end
  endtask

  task automatic test_reserved();
    op_valid = 1'b1; op_code = 3'b111; push_data = 24'h777777; txs_data = 8'h55;
    tick();
    op_valid = 1'b0;
    n_cmp++; if (sp !== 8'h00) begin n_err++; $display("FAIL rsv_sp: got %h want 00", sp); end
    n_cmp++; if ({op_ready, mem_we, mem_re, pull_valid} !== 4'b1000) begin n_err++; $display("FAIL rsv_ctrl: got %b want 1000", {op_ready, mem_we, mem_re, pull_valid}); end
    n_cmp++; if (pull_data !== 24'h0012AA) begin n_err++; $display("FAIL rsv_pdata: got %h want 0012aa", pull_data); end
  endtask

  task automatic test_stall();
    rst = 1'b1; tick(); rst = 1'b0;
    op_valid = 1'b1; op_code = 3'b100; push_data = 24'hC0FFEE;
    tick();
    op_valid = 1'b0;
    n_cmp++; if ({mem_addr, mem_wdata} !== {16'h01FD, 8'hC0}) begin n_err++; $display("FAIL stall_w1: got %h/%h want 01fd/c0", mem_addr, mem_wdata); end
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({mem_addr, mem_wdata, sp, mem_we} !== {16'h01FC, 8'hFF, 8'hFC, 1'b1}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got addr %h data %h sp %h we %b want 01fc ff fc 1", i, mem_addr, mem_wdata, sp, mem_we);
      end
    end
    rdy = 1'b1;
    tick();
    n_cmp++; if ({mem_addr, mem_wdata, sp} !== {16'h01FB, 8'hEE, 8'hFB}) begin n_err++; $display("FAIL stall_w3: got %h/%h sp %h want 01fb/ee fb", mem_addr, mem_wdata, sp); end
    tick();
    n_cmp++; if ({sp, op_ready, mem_we} !== {8'hFA, 1'b1, 1'b0}) begin n_err++; $display("FAIL stall_done: got sp %h rdy %b we %b want fa 1 0", sp, op_ready, mem_we); end
  endtask

  task automatic test_abort();
    rst = 1'b1; tick(); rst = 1'b0;
    op_valid = 1'b1; op_code = 3'b100; push_data = 24'h112233;
    tick();
    op_valid = 1'b0;
    n_cmp++; if ({mem_addr, mem_we} !== {16'h01FD, 1'b1}) begin n_err++; $display("FAIL abort_w1: got %h we %b want 01fd 1", mem_addr, mem_we); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({sp, op_ready, mem_we} !== {8'hFD, 1'b1, 1'b0}) begin n_err++; $display("FAIL abort_rst: got sp %h rdy %b we %b want fd 1 0", sp, op_ready, mem_we); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({mem_we, sp} !== {1'b0, 8'hFD}) begin n_err++; $display("FAIL abort_nowrite%0d: got we %b sp %h want 0 fd", i, mem_we, sp); end
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 3'b000; push_data = 24'h0;
    txs_data = 8'h00; rdy = 1'b1; mem_rdata = 8'h00;
    test_reset();
    test_jsr();
    test_rts();
    test_wrap();
    test_reserved();
    test_stall();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
